// File: rtl/stopwatch_ctrl_if.sv
// Button, live-digit and display signals exchanged between the board side and stopwatch_ctrl.
interface stopwatch_ctrl_if;
    logic       btn_run;
    logic       btn_lap;
    logic       btn_clear;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       run;
    logic       clear;
    logic [3:0] disp0, disp1, disp2, disp3;
    logic       lap_active;
    logic [1:0] state;

    modport master (
        output btn_run, btn_lap, btn_clear, digit0, digit1, digit2, digit3,
        input  run, clear, disp0, disp1, disp2, disp3, lap_active, state
    );
    modport slave (
        input  btn_run, btn_lap, btn_clear, digit0, digit1, digit2, digit3,
        output run, clear, disp0, disp1, disp2, disp3, lap_active, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch button controller: per-button debounce into press events, start/pause/lap/clear
// FSM driving run/clear, and a live-or-latched display mux.
module stopwatch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_WIDTH        = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);
    localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]          sync_q, sync_d;
    logic [DB_WIDTH-1:0] cnt_q, cnt_d;
    logic                stable_q, stable_d;
    logic                stable_prev_q, stable_prev_d;
    logic                press_q, press_d;

    always_comb begin
        sync_d        = {sync_q[0], btn_raw};
        stable_d      = stable_q;
        cnt_d         = '0;
        stable_prev_d = stable_q;
        // A level is accepted only after it has differed on DEBOUNCE_CYCLES consecutive cycles.
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) stable_d = sync_q[1];
            else                   cnt_d    = cnt_q + DB_WIDTH'(1);
        end
        press_d = stable_q & ~stable_prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q        <= '0;
            cnt_q         <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            press_q       <= press_d;
        end
    end

    assign press = press_q;
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_WIDTH        = 20
) (
    input logic             clk,
    input logic             reset,
    stopwatch_ctrl_if.slave sw
);
    localparam int NUM_BTN = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        LAP     = 2'b10,
        PAUSED  = 2'b11
    } state_e;

    logic [NUM_BTN-1:0] btn_raw, press;
    logic [3:0][3:0]    digits;
    logic               run_ev, lap_ev, clr_ev;

    state_e          state_q, state_d;
    logic            run_q, run_d;
    logic            clear_q, clear_d;
    logic            lap_active_q, lap_active_d;
    logic [3:0][3:0] latch_q, latch_d;
    logic [3:0][3:0] disp_q, disp_d;

    assign btn_raw = {sw.btn_clear, sw.btn_lap, sw.btn_run};
    assign digits  = {sw.digit3, sw.digit2, sw.digit1, sw.digit0};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        stopwatch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DB_WIDTH       (DB_WIDTH)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_raw[g]),
            .press  (press[g])
        );
    end

    // Same-cycle events resolve run > lap > clear; losers are dropped even if the winner is ignored.
    assign run_ev = press[0];
    assign lap_ev = press[1] & ~press[0];
    assign clr_ev = press[2] & ~press[1] & ~press[0];

    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        latch_d = latch_q;
        case (state_q)
            IDLE: begin
                if (run_ev)      state_d = RUNNING;
                else if (clr_ev) clear_d = 1'b1;
            end
            RUNNING: begin
                if (run_ev) state_d = PAUSED;
                else if (lap_ev) begin
                    state_d = LAP;
                    latch_d = digits;
                end
            end
            LAP: begin
                if (run_ev)      state_d = PAUSED;
                else if (lap_ev) state_d = RUNNING;
            end
            PAUSED: begin
                if (run_ev) state_d = RUNNING;
                else if (clr_ev) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        run_d        = (state_d == RUNNING) || (state_d == LAP);
        lap_active_d = (state_d == LAP);
        disp_d       = lap_active_d ? latch_d : digits;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            run_q        <= 1'b0;
            clear_q      <= 1'b0;
            lap_active_q <= 1'b0;
            latch_q      <= '0;
            disp_q       <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            clear_q      <= clear_d;
            lap_active_q <= lap_active_d;
            latch_q      <= latch_d;
            disp_q       <= disp_d;
        end
    end

    assign sw.run        = run_q;
    assign sw.clear      = clear_q;
    assign sw.lap_active = lap_active_q;
    assign sw.state      = state_q;
    assign sw.disp0      = disp_q[0];
    assign sw.disp1      = disp_q[1];
    assign sw.disp2      = disp_q[2];
    assign sw.disp3      = disp_q[3];
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Button-level controller that sequences the stopwatch datapath.
- Debounces three raw pushbuttons and turns each into a single press event.
- Runs a start/pause/lap/clear state machine that drives the stopwatch `run` enable and a clear pulse. The top level ORs the clear pulse with `reset` to form the stopwatch reset.
- Muxes the displayed digits between the live count and a latched lap value.
- Sits between board buttons, the stopwatch, and the SSD driver.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive synchronized cycles a button must hold a new level before it is accepted (10 ms at 100 MHz).
- DB_WIDTH, 20: width of each debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_run  input  1  raw async start/pause button.
- btn_lap  input  1  raw async lap button.
- btn_clear  input  1  raw async clear button.
- digit0, digit1, digit2, digit3  input  4 each  live stopwatch digits.
- run  output  1  stopwatch count enable.
- clear  output  1  one-cycle stopwatch clear pulse.
- disp0, disp1, disp2, disp3  output  4 each  digits to display.
- lap_active  output  1  high while the display is frozen.
- state  output  2  current FSM state encoding.

Behaviour:
- Reset (synchronous, highest priority):
  - State goes to IDLE; run=0, clear=0, lap_active=0, disp0-3=0.
  - All synchronizers, debounce counters, stable levels and lap latches clear to 0.
- Per-button debounce (three identical, independent instances):
  - 2-FF synchronizer, then a counter.
  - If synced level == stable level, counter <= 0.
  - Otherwise counter increments; when counter == DEBOUNCE_CYCLES-1 and still differing, stable <= synced and counter <= 0.
  - Press event = registered pulse on the stable 0->1 transition; exactly 1 cycle wide.
  - Releases (1->0) debounce the same way but generate no event.
  - A glitch shorter than DEBOUNCE_CYCLES resets the counter and produces no event.
- Latency: btn held high from edge 1 -> run/clear/lap_active change after edge DEBOUNCE_CYCLES+4.
- FSM (registered; outputs registered, decoded from the next state):
  - IDLE (00): run=0, live display.
    - run event -> RUNNING.
    - clear event -> clear pulses 1 cycle, stay IDLE.
    - lap event ignored.
  - RUNNING (01): run=1, live display.
    - run event -> PAUSED.
    - lap event -> LAP; latch digit0-3 as sampled in the event cycle.
    - clear event ignored.
  - LAP (10): run=1, display shows latched value, lap_active=1.
    - lap event -> RUNNING (display returns to live).
    - run event -> PAUSED (latch released, live display).
    - clear event ignored.
  - PAUSED (11): run=0, live display.
    - run event -> RUNNING.
    - clear event -> IDLE with a 1-cycle clear pulse.
    - lap event ignored.
- Simultaneous events in one cycle: priority run > lap > clear; only the winner acts, the others are dropped.
- Display path:
  - disp* are registered: disp <= lap_active_next ? latch : digit*.
  - Live display lags digit inputs by 1 cycle.
  - Lap latch updates only on the RUNNING->LAP transition; its value persists in the LAP state regardless of digit changes.
- clear is never asserted in RUNNING or LAP, so the counter is never cleared while running.
- Reset mid-operation (any state, any debounce in progress): next cycle matches the reset values above. A button still held after reset must re-qualify and then produces one event.
- A held button produces exactly one event per press, irrespective of hold length.

Test Plan (DEBOUNCE_CYCLES=4, DB_WIDTH=3):
1. After reset, hold btn_run 20 cycles from edge 1 -> run rises after edge 8, state=01, exactly one event; release then press again -> state=11, run=0.
2. Pulse btn_run high for 3 cycles, 5 times with gaps -> no event, state stays 00, run=0.
3. In RUNNING with digits=1,2,3,4, press lap -> lap_active=1, state=10, disp=1,2,3,4 while digits advance to 5,6,7,8; press lap again -> disp follows live digits 1 cycle late, state=01.
4. RUNNING -> run press -> PAUSED; clear press -> clear high exactly 1 cycle, state=00. In RUNNING, a clear press -> clear stays 0, state unchanged.
5. In RUNNING, assert btn_run and btn_lap on the same edge, held 10 cycles -> state=11 (run wins), lap_active=0, no latch update.
6. In LAP with btn_clear mid-debounce, assert reset for 1 cycle -> all outputs 0, state=00; btn_clear still held -> one clear pulse 8 cycles after reset deasserts.
